perf_event_counters: RTL

//  In-RTL performance counter bank. It consumes the same core event signals that the
//  DPI perf monitor taps: fetch, exec, icache, LSU and branch predictor.
//  It accumulates them in hardware counters, so statistics survive non-DPI flows
//  (FPGA, gate-level).

---
 rtl/perf_event_counters_pkg.sv | 24 ++
 rtl/perf_event_counters_if.sv | 39 +++
 rtl/perf_counter_cell.sv | 41 ++++
 rtl/perf_event_counters.sv | 107 ++++++++++
 4 files changed

// File: rtl/perf_event_counters_pkg.sv
// Shared constants for the performance counter bank: counter indices, read-index width,
// and the icache miss-tracking FSM state type.
package perf_pkg;

    localparam int unsigned PERF_CYCLE      = 0;
    localparam int unsigned PERF_INSTR      = 1;
    localparam int unsigned PERF_FETCH      = 2;
    localparam int unsigned PERF_IC_HIT     = 3;
    localparam int unsigned PERF_IC_MISS    = 4;
    localparam int unsigned PERF_IC_PENALTY = 5;
    localparam int unsigned PERF_LSU_RD     = 6;
    localparam int unsigned PERF_LSU_WR     = 7;
    localparam int unsigned PERF_LSU_WAIT   = 8;
    localparam int unsigned PERF_BR_OK      = 9;
    localparam int unsigned PERF_BR_FAIL    = 10;
    localparam int unsigned NUM_PERF        = 11;
    localparam int unsigned IDX_W           = 4;

    typedef enum logic {
        StIdle,
        StWait
    } miss_state_e;

endpackage

// File: rtl/perf_event_counters_if.sv
// Event taps, control and read-port signals of the performance counter bank.
// The master side is the core/host; the slave side is the counter bank.
interface perf_event_counters_if
    import perf_pkg::*;
#(
    parameter int unsigned CNT_W = 64
);
    logic                 ifu_valid;
    logic                 idu_ready;
    logic                 exu_valid;
    logic                 icache_start;
    logic                 icache_valid;
    logic                 icache_is_hit;
    logic                 lsu_ren;
    logic                 lsu_wen;
    logic                 lsu_is_waiting;
    logic                 branch_predict_success;
    logic                 branch_predict_failed;
    logic                 clear;
    logic                 freeze;
    logic [IDX_W-1:0]     rd_idx;
    logic [CNT_W-1:0]     rd_data;
    logic [NUM_PERF-1:0]  ovf;

    modport master (
        output ifu_valid, idu_ready, exu_valid, icache_start, icache_valid, icache_is_hit,
               lsu_ren, lsu_wen, lsu_is_waiting, branch_predict_success,
               branch_predict_failed, clear, freeze, rd_idx,
        input  rd_data, ovf
    );

    modport slave (
        input  ifu_valid, idu_ready, exu_valid, icache_start, icache_valid, icache_is_hit,
               lsu_ren, lsu_wen, lsu_is_waiting, branch_predict_success,
               branch_predict_failed, clear, freeze, rd_idx,
        output rd_data, ovf
    );

endinterface

// File: rtl/perf_counter_cell.sv
// One event counter with synchronous clear, freeze, optional saturation and a sticky
// overflow flag. Clear beats freeze, freeze beats increment.
module perf_counter_cell #(
    parameter int unsigned CNT_W    = 64,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    input  logic             i_clear,
    input  logic             i_freeze,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_ovf
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_clear) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_inc && !i_freeze) begin
            if (&r_cnt) begin
                r_ovf <= 1'b1;
                if (!SATURATE) begin
                    r_cnt <= '0;
                end
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_cnt = r_cnt;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/perf_event_counters.sv
// Hardware performance counter bank: edge detectors, icache miss-penalty FSM, eleven
// counter cells and a registered indexed read port.
module perf_event_counters
    import perf_pkg::*;
#(
    parameter int unsigned CNT_W    = 64,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    perf_event_counters_if.slave  io_perf
);

    logic                r_start_q;
    logic                r_wait_q;
    miss_state_e         r_state;
    miss_state_e         w_state_next;
    logic [CNT_W-1:0]    r_rd_data;
    logic [CNT_W-1:0]    w_rd_sel;
    logic                w_start_rise;
    logic                w_wait_rise;
    logic                w_fetch;
    logic                w_penalty;
    logic [NUM_PERF-1:0] w_inc;
    logic [NUM_PERF-1:0] w_ovf;
    logic [CNT_W-1:0]    w_cnt [NUM_PERF];

    assign w_start_rise = io_perf.icache_start & ~r_start_q;
    assign w_wait_rise  = io_perf.lsu_is_waiting & ~r_wait_q;
    assign w_fetch      = io_perf.ifu_valid & io_perf.idu_ready;

    // Edge history and miss FSM ignore clear/freeze so later events stay correctly attributed
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_start_q <= 1'b0;
            r_wait_q  <= 1'b0;
            r_state   <= StIdle;
            r_rd_data <= '0;
        end else begin
            r_start_q <= io_perf.icache_start;
            r_wait_q  <= io_perf.lsu_is_waiting;
            r_state   <= w_state_next;
            r_rd_data <= w_rd_sel;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_penalty    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_start_rise && !io_perf.icache_valid) begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (io_perf.icache_valid) begin
                    w_state_next = StIdle;
                end else begin
                    w_penalty = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        w_inc                  = '0;
        w_inc[PERF_CYCLE]      = 1'b1;
        w_inc[PERF_INSTR]      = io_perf.exu_valid;
        w_inc[PERF_FETCH]      = w_fetch;
        w_inc[PERF_IC_HIT]     = w_fetch & io_perf.icache_is_hit;
        w_inc[PERF_IC_MISS]    = w_start_rise;
        w_inc[PERF_IC_PENALTY] = w_penalty;
        w_inc[PERF_LSU_RD]     = w_wait_rise & io_perf.lsu_ren;
        w_inc[PERF_LSU_WR]     = w_wait_rise & io_perf.lsu_wen;
        w_inc[PERF_LSU_WAIT]   = io_perf.lsu_is_waiting;
        w_inc[PERF_BR_OK]      = io_perf.branch_predict_success;
        w_inc[PERF_BR_FAIL]    = io_perf.branch_predict_failed;
    end

    for (genvar gi = 0; gi < NUM_PERF; gi++) begin : g_cnt
        perf_counter_cell #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_cell (
            .i_clk    (i_clk),
            .i_reset  (i_reset),
            .i_inc    (w_inc[gi]),
            .i_clear  (io_perf.clear),
            .i_freeze (io_perf.freeze),
            .o_cnt    (w_cnt[gi]),
            .o_ovf    (w_ovf[gi])
        );
    end

    // Out-of-range indices read as zero
    always_comb begin
        w_rd_sel = '0;
        if (io_perf.rd_idx < IDX_W'(NUM_PERF)) begin
            w_rd_sel = w_cnt[io_perf.rd_idx];
        end
    end

    assign io_perf.rd_data = r_rd_data;
    assign io_perf.ovf     = w_ovf;

endmodule
